// File: rtl/op_counter_gen_if.sv
// Control and status bundle for op_counter_gen. The master side drives
// clr, load and op; the slave side returns count, in_loop, wrap_pulse and tally.
interface op_counter_gen_if #(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned TALLY_W = 8
);
  logic               clr;
  logic               load;
  logic [WIDTH-1:0]   load_val;
  logic               op;
  logic               dir;
  logic [WIDTH-1:0]   count;
  logic               in_loop;
  logic               wrap_pulse;
  logic [TALLY_W-1:0] tally;

  modport master (
    output clr, load, load_val, op, dir,
    input  count, in_loop, wrap_pulse, tally
  );

  modport slave (
    input  clr, load, load_val, op, dir,
    output count, in_loop, wrap_pulse, tally
  );
endinterface

// File: rtl/op_counter_gen.sv
// Operation counter: a linear prefix up to WRAP_LO-1, then a loop over WRAP_LO..WRAP_HI.
// Supports up/down steps, clear, load, a wrap pulse and a saturating tally. Define
// OPCNT_EDGE_EN to synchronise op and step once per rising edge of op.
module op_counter_gen #(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned WRAP_LO = 2,
  parameter int unsigned WRAP_HI = 5,
  parameter int unsigned RST_VAL = 0,
  parameter int unsigned TALLY_W = 8
) (
  input  logic            clock,
  input  logic            rst,
  op_counter_gen_if.slave bus
);
  localparam logic [WIDTH-1:0] LO_V  = WIDTH'(WRAP_LO);
  localparam logic [WIDTH-1:0] HI_V  = WIDTH'(WRAP_HI);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);

  logic [WIDTH-1:0]   count_q, count_d;
  logic               pulse_q, pulse_d;
  logic [TALLY_W-1:0] tally_q, tally_d;
  logic               step;

`ifdef OPCNT_EDGE_EN
  // sync_q[1:0] form the two-flop synchroniser; sync_q[2] holds the previous
  // synchronised level, so step fires for exactly one cycle per rising edge.
  logic [2:0] sync_q;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[1:0], bus.op};
  end

  assign step = sync_q[1] & ~sync_q[2];
`else
  assign step = bus.op;
`endif

  always_comb begin
    count_d = count_q;
    pulse_d = 1'b0;
    tally_d = tally_q;
    if (bus.clr) begin
      count_d = RST_V;
      tally_d = '0;
    end else if (bus.load) begin
      count_d = bus.load_val;
    end else if (step) begin
      if (!bus.dir) begin
        if (count_q >= HI_V) begin
          count_d = LO_V;
          pulse_d = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        // The loop-entry check comes first so that WRAP_LO==0 still wraps from 0.
        if (count_q == LO_V) begin
          count_d = HI_V;
          pulse_d = 1'b1;
        end else if (count_q != '0) begin
          count_d = count_q - 1'b1;
        end
      end
      if (pulse_d && (tally_q != '1)) tally_d = tally_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      count_q <= RST_V;
      pulse_q <= 1'b0;
      tally_q <= '0;
    end else begin
      count_q <= count_d;
      pulse_q <= pulse_d;
      tally_q <= tally_d;
    end
  end

  assign bus.count      = count_q;
  assign bus.wrap_pulse = pulse_q;
  assign bus.tally      = tally_q;
  assign bus.in_loop    = (count_q >= LO_V) && (count_q <= HI_V);
endmodule
